// File: rtl/cache_fill_arbiter_if.sv
// Bundle between the I/D cache miss requesters, the memory port and the fill return path.
interface cache_fill_arbiter_if;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_data_valid;
    logic [15:0] mem_data_out;
    logic        fill_valid;
    logic        fill_owner;
    logic [2:0]  fill_idx;
    logic [15:0] fill_data;
    logic        i_done;
    logic        d_done;
    logic        busy;

    // master: the arbiter itself; slave: the caches and memory around it
    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_valid, mem_data_out,
        output mem_en, mem_wr, mem_addr, mem_wdata, fill_valid, fill_owner, fill_idx, fill_data,
        output i_done, d_done, busy
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_valid, mem_data_out,
        input  mem_en, mem_wr, mem_addr, mem_wdata, fill_valid, fill_owner, fill_idx, fill_data,
        input  i_done, d_done, busy
    );
endinterface

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I/D cache misses onto one memory port and streams fill words back.
// Define ARB_RR_EN for round-robin on contention; default build gives priority to D.
module cache_fill_arbiter #(
    parameter int unsigned BLOCK_WORDS = 8
) (
    input logic                 clk,
    input logic                 rst,
    cache_fill_arbiter_if.master bus
);
    typedef enum logic [2:0] {StIdle, StFill, StDrain, StWrite, StDone} state_e;

    localparam logic [2:0] LastIdx = 3'(BLOCK_WORDS - 1);

    state_e      state_q, state_d;
    logic [2:0]  issue_q, issue_d;
    logic [2:0]  recv_q, recv_d;
    logic        owner_q, owner_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        grant_d_side;

    logic        mem_en, mem_wr, fill_valid, fill_owner, i_done, d_done;
    logic [15:0] mem_addr, mem_wdata, fill_data;
    logic [2:0]  fill_idx;

`ifdef ARB_RR_EN
    logic last_d_q, last_d_d;

    // On contention the side that did not win last time gets the grant.
    assign grant_d_side = bus.d_req && (!bus.i_req || !last_d_q);
`else
    assign grant_d_side = bus.d_req;
`endif

    always_comb begin
        state_d    = state_q;
        issue_d    = issue_q;
        recv_d     = recv_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef ARB_RR_EN
        last_d_d   = last_d_q;
`endif
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_valid = 1'b0;
        fill_owner = 1'b0;
        fill_idx   = '0;
        fill_data  = '0;
        i_done     = 1'b0;
        d_done     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.i_req || bus.d_req) begin
                    owner_d = grant_d_side;
                    wdata_d = bus.d_wdata;
                    issue_d = '0;
                    recv_d  = '0;
`ifdef ARB_RR_EN
                    last_d_d = grant_d_side;
`endif
                    if (grant_d_side) begin
                        // Writes target the exact word; fills start at the block base.
                        addr_d  = bus.d_we ? bus.d_addr : (bus.d_addr & 16'hFFF0);
                        state_d = bus.d_we ? StWrite : StFill;
                    end else begin
                        addr_d  = bus.i_addr & 16'hFFF0;
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                mem_en   = 1'b1;
                mem_addr = addr_q + {12'b0, issue_q, 1'b0};
                issue_d  = issue_q + 3'd1;
                if (issue_q == LastIdx) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
            end
            StWrite: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                state_d   = StDone;
            end
            StDone: begin
                i_done  = !owner_q;
                d_done  = owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Returns are accepted in both FILL and DRAIN; the last word ends the fill either way.
        if ((state_q == StFill || state_q == StDrain) && bus.mem_data_valid) begin
            fill_valid = 1'b1;
            fill_owner = owner_q;
            fill_idx   = recv_q;
            fill_data  = bus.mem_data_out;
            recv_d     = recv_q + 3'd1;
            if (recv_q == LastIdx) begin
                state_d = StDone;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            issue_q  <= '0;
            recv_q   <= '0;
            owner_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
`ifdef ARB_RR_EN
            last_d_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            issue_q  <= issue_d;
            recv_q   <= recv_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
`ifdef ARB_RR_EN
            last_d_q <= last_d_d;
`endif
        end
    end

    // Outputs are forced low while reset is held, even before the state register clears.
    assign bus.mem_en     = !rst && mem_en;
    assign bus.mem_wr     = !rst && mem_wr;
    assign bus.mem_addr   = rst ? '0 : mem_addr;
    assign bus.mem_wdata  = rst ? '0 : mem_wdata;
    assign bus.fill_valid = !rst && fill_valid;
    assign bus.fill_owner = !rst && fill_owner;
    assign bus.fill_idx   = rst ? '0 : fill_idx;
    assign bus.fill_data  = rst ? '0 : fill_data;
    assign bus.i_done     = !rst && i_done;
    assign bus.d_done     = !rst && d_done;
    assign bus.busy       = !rst && (state_q != StIdle);
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed plus random transactions against a transaction-level model of the fill arbiter.
module tb_cache_fill_arbiter;
    localparam int unsigned BW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_fill_arbiter_if bus ();

    cache_fill_arbiter #(.BLOCK_WORDS(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [15:0] q_addr[$];
    int          q_due[$];
    bit          holdoff = 1'b0;
    bit          model_last_d = 1'b0;
`ifdef ARB_RR_EN
    bit          rr = 1'b1;
`else
    bit          rr = 1'b0;
`endif

    logic        e_en, e_wr, e_fv, e_own, e_idone, e_ddone, e_busy;
    logic [15:0] e_addr, e_wdata, e_fdata;
    logic [2:0]  e_idx;

    function automatic logic [15:0] memfn(input logic [15:0] a);
        return (a * 16'd7) ^ 16'h5A3C;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cycle);
        end
    endtask

    task automatic set_idle_exp();
        e_en = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
        e_fv = 0; e_own = 0; e_idx = '0; e_fdata = '0;
        e_idone = 0; e_ddone = 0; e_busy = 0;
    endtask

    // Memory responder: one return per cycle, no earlier than 4 cycles after issue.
    task automatic drive_mem();
        bus.mem_data_valid = 1'b0;
        bus.mem_data_out   = 16'($urandom);
        if (q_due.size() > 0 && q_due[0] <= cycle && (!holdoff || $urandom_range(0, 2) == 0)) begin
            bus.mem_data_valid = 1'b1;
            bus.mem_data_out   = memfn(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("mem_en", bus.mem_en, e_en);
        chk("mem_wr", bus.mem_wr, e_wr);
        chk("mem_addr", bus.mem_addr, e_addr);
        chk("mem_wdata", bus.mem_wdata, e_wdata);
        chk("fill_valid", bus.fill_valid, e_fv);
        chk("fill_owner", bus.fill_owner, e_own);
        chk("fill_idx", bus.fill_idx, e_idx);
        chk("fill_data", bus.fill_data, e_fdata);
        chk("i_done", bus.i_done, e_idone);
        chk("d_done", bus.d_done, e_ddone);
        chk("busy", bus.busy, e_busy);
        if (bus.mem_en && !bus.mem_wr) begin
            q_addr.push_back(bus.mem_addr);
            q_due.push_back(cycle + 4);
        end
        @(posedge clk);
        #1;
        cycle++;
        drive_mem();
    endtask

    task automatic drain();
        holdoff = 1'b0;
        for (int t = 0; t < 60 && (q_due.size() > 0 || t < 2); t++) begin
            set_idle_exp();
            tick();
        end
    endtask

    // abort_k >= 1 asserts rst in that cycle after the grant
    task automatic run_txn(input bit ri, input bit rd, input bit we, input logic [15:0] ia,
                           input logic [15:0] da, input logic [15:0] wd, input bit hold,
                           input int abort_k);
        bit          own_d, is_wr, finished;
        logic [15:0] base;
        int          n, k, recv, done_c;
        if (ri && rd) own_d = rr ? !model_last_d : 1'b1;
        else          own_d = rd;
        model_last_d = own_d;
        is_wr = own_d && we;
        base  = own_d ? (is_wr ? da : (da & 16'hFFF0)) : (ia & 16'hFFF0);
        holdoff = hold;
        bus.i_req = ri; bus.i_addr = ia; bus.d_req = rd; bus.d_we = we;
        bus.d_addr = da; bus.d_wdata = wd;
        n = cycle; recv = 0; finished = 0; done_c = -1;
        for (int t = 0; t < 200; t++) begin
            k = cycle - n;
            if (k >= 1) begin
                bus.i_addr = 16'($urandom); bus.d_addr = 16'($urandom);
                bus.d_wdata = 16'($urandom); bus.d_we = 1'($urandom);
            end
            rst = (k == abort_k);
            set_idle_exp();
            if (!rst && k >= 1) begin
                e_busy = 1;
                if (is_wr) begin
                    if (k == 1) begin
                        e_en = 1; e_wr = 1; e_addr = base; e_wdata = wd;
                    end else begin
                        e_ddone = 1;
                    end
                end else begin
                    if (k <= BW) begin
                        e_en = 1; e_addr = base + 16'(2 * (k - 1));
                    end
                    if (recv == BW) begin
                        e_idone = !own_d; e_ddone = own_d;
                    end else if (bus.mem_data_valid) begin
                        e_fv = 1; e_own = own_d; e_idx = 3'(recv);
                        e_fdata = memfn(base + 16'(2 * recv));
                        recv++;
                    end
                end
            end
            tick();
            if (rst) begin
                rst = 1'b0;
                model_last_d = 1'b0;
                finished = 1;
                break;
            end
            if (e_idone || e_ddone) begin
                done_c = cycle - 1;
                finished = 1;
                break;
            end
        end
        bus.i_req = 0; bus.d_req = 0; bus.d_we = 0;
        chk("txn_finished", 16'(finished), 16'd1);
        if (!hold && !is_wr && abort_k < 0) chk("read_latency", 16'(done_c - n), 16'(5 + BW));
        if (is_wr) chk("write_latency", 16'(done_c - n), 16'd2);
        drain();
    endtask

    initial begin
        bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_data_valid = 0; bus.mem_data_out = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            set_idle_exp();
            tick();
        end
        rst = 1'b0;
        drain();

        run_txn(1, 0, 0, 16'h1236, 16'h0000, 16'h0000, 0, -1);
        run_txn(0, 1, 1, 16'h0000, 16'h0040, 16'hBEEF, 0, -1);
        for (int i = 0; i < 3; i++) begin
            run_txn(1, 1, 0, 16'h2000 + 16'(i * 16'h40), 16'h3000 + 16'(i * 16'h40), 16'h0, 0, -1);
        end
        run_txn(1, 0, 0, 16'h4450, 16'h0000, 16'h0000, 0, 3);
        run_txn(0, 1, 0, 16'h0000, 16'h5A5A, 16'h0000, 1, -1);

        for (int i = 0; i < 20; i++) begin
            bit ri, rd;
            ri = 1'($urandom);
            rd = ri ? 1'($urandom) : 1'b1;
            run_txn(ri, rd, 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    1'($urandom), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_fill_arbiter.md
CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

Interface
REQ-001 The block SHALL have parameter BLOCK_WORDS, default 8, giving the number of 16-bit words per cache block; it SHALL be a power of two from 2 to 8.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  reset; synchronous, active-high
- i_req  in  1  I-cache miss request, level, held until i_done
- i_addr  in  16  I-side miss byte address
- d_req  in  1  D-cache request, level, held until d_done
- d_we  in  1  D request is a write (1) or a miss fill (0)
- d_addr  in  16  D-side byte address
- d_wdata  in  16  D-side write data
- mem_en  out  1  memory access strobe
- mem_wr  out  1  memory write enable
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  memory write data
- mem_data_valid  in  1  read data return strobe; memory latency fixed at 4 cycles
- mem_data_out  in  16  read return data
- fill_valid  out  1  fill_data is the word at fill_idx
- fill_owner  out  1  0 = I-cache, 1 = D-cache
- fill_idx  out  3  word index within block
- fill_data  out  16  fill word
- i_done, d_done  out  1  one-cycle completion pulses
- busy  out  1  FSM not in IDLE

Function
REQ-003 The FSM SHALL have states IDLE, FILL, DRAIN, WRITE and DONE.
REQ-004 In IDLE with no request, the FSM SHALL stay in IDLE with mem_en=0.
REQ-005 In IDLE with requests pending, arbitration SHALL grant one requester and latch owner, the block base (addr with bits [3:0] cleared), d_we and d_wdata.
REQ-006 A grant of a read (i_req, or d_req with d_we=0) SHALL go to FILL; a grant of d_req with d_we=1 SHALL go to WRITE.
REQ-007 FILL SHALL last exactly BLOCK_WORDS cycles, asserting mem_en=1, mem_wr=0 and mem_addr = base + 2*issue_cnt, with issue_cnt running 0..BLOCK_WORDS-1; it SHALL then go to DRAIN.
REQ-008 In FILL and DRAIN, each mem_data_valid SHALL produce fill_valid=1 in the same cycle, with fill_data = mem_data_out, fill_idx = recv_cnt and fill_owner = latched owner; recv_cnt SHALL then increment.
REQ-009 When the word with recv_cnt = BLOCK_WORDS-1 is received, the FSM SHALL go to DONE, whether it is in FILL or DRAIN.
REQ-010 WRITE SHALL last one cycle, asserting mem_en=1, mem_wr=1, mem_addr = latched d_addr and mem_wdata = d_wdata, then go to DONE.
REQ-011 DONE SHALL last one cycle, pulse i_done or d_done according to the latched owner, and return to IDLE.
REQ-012 A requester SHALL deassert its request in the cycle after its done pulse; a request still high in IDLE SHALL be treated as a new request.
REQ-013 Latency for a read granted in IDLE at cycle N: first mem_en at N+1; word 0 at N+5; last word at N+4+BLOCK_WORDS; done at N+5+BLOCK_WORDS.
REQ-014 mem_data_valid SHALL be ignored in IDLE, WRITE and DONE.
REQ-015 Request and address changes while busy SHALL be ignored.
REQ-016 Outputs mem_wr, mem_addr and mem_wdata SHALL be 0 whenever mem_en=0.
REQ-017 busy SHALL be 1 in every state except IDLE.

Reset
REQ-018 rst SHALL force IDLE from any state, including mid-FILL or mid-DRAIN.
REQ-019 rst SHALL clear both counters, the owner and the last-grant register.
REQ-020 During and after rst, all outputs SHALL be 0.
REQ-021 No done pulse SHALL be issued for an operation aborted by reset; late returns from that operation are discarded per REQ-014.

Configuration
REQ-022 Macro ARB_RR_EN SHALL select the arbitration policy.
REQ-023 Without ARB_RR_EN, when both i_req and d_req are high, D SHALL win.
REQ-024 With ARB_RR_EN, when both are high, the requester not granted most recently SHALL win; the last-grant register SHALL reset to I, so D wins the first contention.
REQ-025 A single pending requester SHALL always be granted, with or without ARB_RR_EN.

Verification
REQ-026 i_req=1, i_addr=0x1236 -> mem_addr 0x1230, 0x1232 .. 0x123E on 8 consecutive cycles; fill_idx 0..7 with owner 0; i_done at N+13.
REQ-027 d_req=1, d_we=1, d_addr=0x0040, d_wdata=0xBEEF -> one cycle with mem_en=1, mem_wr=1, addr 0x0040, data 0xBEEF; d_done the next cycle.
REQ-028 i_req and d_req both rising in the same cycle, repeated 3 times -> without ARB_RR_EN, D is granted all 3 times; with ARB_RR_EN, grants are D, I, D.
REQ-029 rst asserted at the 3rd FILL cycle -> next cycle IDLE with all outputs 0; memory returns arriving later give fill_valid=0 and no done pulse.
REQ-030 d_req read miss with mem_data_valid held off, so returns are spaced irregularly -> the FSM waits in DRAIN, fill_idx stays in order 0..7, and d_done occurs one cycle after the 8th valid.
